// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: instruction fields, memory handshake and datapath strobes between sequencer and datapath.
interface multicycle_ctrl_if #(parameter int ALU_CC_W = 4, parameter int CNT_W = 16);
  logic                run;
  logic [6:0]          opcode;
  logic [2:0]          funct3;
  logic [6:0]          funct7;
  logic                mem_ready;
  logic                pc_en;
  logic                ir_en;
  logic                reg_write;
  logic                mem2reg;
  logic                alu_src;
  logic                mem_write;
  logic                mem_read;
  logic [ALU_CC_W-1:0] alu_cc;
  logic                busy;
  logic                trap;
  logic [2:0]          state;
  logic [CNT_W-1:0]    retired;
  modport master (
    output run, opcode, funct3, funct7, mem_ready,
    input  pc_en, ir_en, reg_write, mem2reg, alu_src, mem_write, mem_read, alu_cc, busy, trap, state, retired
  );
  modport slave (
    input  run, opcode, funct3, funct7, mem_ready,
    output pc_en, ir_en, reg_write, mem2reg, alu_src, mem_write, mem_read, alu_cc, busy, trap, state, retired
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle RV32I sequencer with memory-ready timeout, run/halt, illegal-instruction trap and retire counter.
module multicycle_ctrl #(
  parameter int ALU_CC_W = 4,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input logic               clk_i,
  input logic               rst_ni,
  multicycle_ctrl_if.slave  bus
);
  localparam int WW = $clog2(WAIT_MAX + 1);
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LW = 7'b0000011, OP_SW = 7'b0100011;
  localparam logic [6:0] F7_Z = 7'b0000000, F7_ALT = 7'b0100000;
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP} state_e;
  state_e         state_q, state_d;
  logic           r_q, lw_q, sw_q, f7alt_q;
  logic [2:0]     f3_q;
  logic [WW-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0] retired_q;
  logic           is_r, is_i, is_lw, is_sw, f7_ok, legal, act, retire;
  logic [3:0]     cc;
  assign is_r  = bus.opcode == OP_R;
  assign is_i  = bus.opcode == OP_I;
  assign is_lw = bus.opcode == OP_LW && bus.funct3 == 3'b010;
  assign is_sw = bus.opcode == OP_SW && bus.funct3 == 3'b010;
  // SUB/SRA are the only R-type alternates; immediate shifts are the only I-type funct7 checks
  assign f7_ok = is_r ? (bus.funct7 == F7_Z || (bus.funct7 == F7_ALT && (bus.funct3 == 3'b000 || bus.funct3 == 3'b101)))
               : is_i ? (bus.funct3 == 3'b001 ? bus.funct7 == F7_Z
                       : bus.funct3 == 3'b101 ? (bus.funct7 == F7_Z || bus.funct7 == F7_ALT) : 1'b1)
               : 1'b1;
  assign legal  = (is_r || is_i || is_lw || is_sw) && f7_ok;
  assign retire = state_q == WB || (state_q == MEM && sw_q && bus.mem_ready);
  assign act    = state_q == EXEC || state_q == MEM || state_q == WB;
  always_comb begin
    cc = 4'b0010;
    if (!(lw_q || sw_q))
      cc = f3_q == 3'b000 ? (r_q && f7alt_q ? 4'b0110 : 4'b0010)
         : f3_q == 3'b001 ? 4'b0100
         : f3_q == 3'b010 ? 4'b0111
         : f3_q == 3'b011 ? 4'b1001
         : f3_q == 3'b100 ? 4'b0011
         : f3_q == 3'b101 ? (f7alt_q ? 4'b1000 : 4'b0101)
         : f3_q == 3'b110 ? 4'b0001 : 4'b0000;
  end
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      IDLE:    state_d = bus.run ? FETCH : IDLE;
      FETCH:   state_d = DECODE;
      DECODE:  state_d = legal ? EXEC : TRAP;
      EXEC: begin
        state_d = (lw_q || sw_q) ? MEM : WB;
        wait_d  = '0;
      end
      MEM: begin
        state_d = bus.mem_ready ? (lw_q ? WB : bus.run ? FETCH : IDLE)
                : wait_q == WW'(WAIT_MAX) ? TRAP : MEM;
        wait_d  = bus.mem_ready ? wait_q : wait_q + 1'b1;
      end
      WB:      state_d = bus.run ? FETCH : IDLE;
      TRAP:    state_d = TRAP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      retired_q <= '0;
      {r_q, lw_q, sw_q, f7alt_q, f3_q} <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (retire) retired_q <= retired_q + 1'b1;
      if (state_q == DECODE) {r_q, lw_q, sw_q, f7alt_q, f3_q} <= {is_r, is_lw, is_sw, bus.funct7 == F7_ALT, bus.funct3};
    end
  end
  assign bus.pc_en     = retire;
  assign bus.ir_en     = state_q == FETCH;
  assign bus.reg_write = state_q == WB;
  assign bus.mem2reg   = state_q == WB && lw_q;
  assign bus.alu_src   = act && !r_q;
  assign bus.mem_read  = state_q == MEM && lw_q;
  assign bus.mem_write = state_q == MEM && sw_q;
  assign bus.alu_cc    = act ? ALU_CC_W'(cc) : '0;
  assign bus.busy      = state_q != IDLE && state_q != TRAP;
  assign bus.trap      = state_q == TRAP;
  assign bus.state     = state_q;
  assign bus.retired   = retired_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed instruction sequences with hand-computed state, strobe and counter expectations.
module tb_multicycle_ctrl;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LW = 7'b0000011, OP_SW = 7'b0100011;
  localparam logic [6:0] ALT = 7'b0100000;
  logic clk = 0, rst_n = 0;
  int checks = 0, errors = 0;
  multicycle_ctrl_if #(.ALU_CC_W(4), .CNT_W(16)) bus();
  multicycle_ctrl #(.ALU_CC_W(4), .WAIT_MAX(15), .CNT_W(16)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic instr(input logic [6:0] op, input logic [6:0] f7, input logic [2:0] f3);
    bus.opcode = op;
    bus.funct7 = f7;
    bus.funct3 = f3;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    bus.run = 0;
    bus.mem_ready = 0;
    instr(OP_R, 7'd0, 3'b000);
    #12;
    check("rst_state", bus.state, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_trap", bus.trap, 0);
    check("rst_retired", bus.retired, 0);
    check("rst_alu_cc", bus.alu_cc, 0);
    check("rst_strobes", {bus.mem_write, bus.mem_read, bus.reg_write, bus.pc_en, bus.ir_en}, 0);
    @(negedge clk);
    rst_n = 1;
    bus.run = 1;
    step();
    check("add_fetch_state", bus.state, 1);
    check("add_fetch_ir_en", bus.ir_en, 1);
    check("add_fetch_busy", bus.busy, 1);
    step();
    check("add_decode_state", bus.state, 2);
    check("add_decode_ir_en", bus.ir_en, 0);
    step();
    check("add_exec_state", bus.state, 3);
    check("add_exec_alu_cc", bus.alu_cc, 4'b0010);
    check("add_exec_alu_src", bus.alu_src, 0);
    check("add_exec_reg_write", bus.reg_write, 0);
    step();
    check("add_wb_state", bus.state, 5);
    check("add_wb_strobes", {bus.reg_write, bus.pc_en, bus.mem2reg}, 3'b110);
    step();
    check("add_next_fetch", bus.state, 1);
    check("add_retired", bus.retired, 1);
    instr(OP_R, ALT, 3'b000);
    step(2);
    check("sub_alu_cc", bus.alu_cc, 4'b0110);
    step(2);
    check("sub_retired", bus.retired, 2);
    instr(OP_R, ALT, 3'b101);
    step(2);
    check("sra_alu_cc", bus.alu_cc, 4'b1000);
    step(2);
    check("sra_retired", bus.retired, 3);
    instr(OP_LW, 7'd0, 3'b010);
    step(2);
    check("lw_exec_alu_cc", bus.alu_cc, 4'b0010);
    check("lw_exec_alu_src", bus.alu_src, 1);
    step();
    n = 0;
    for (int i = 0; i < 4; i++) begin
      n += (bus.state == 4 && bus.mem_read) ? 1 : 0;
      if (i == 3) bus.mem_ready = 1;
      step();
    end
    check("lw_mem_read_cycles", n, 4);
    check("lw_wb_state", bus.state, 5);
    check("lw_wb_strobes", {bus.reg_write, bus.mem2reg, bus.alu_src, bus.pc_en, bus.mem_read}, 5'b11110);
    check("lw_wb_alu_cc", bus.alu_cc, 4'b0010);
    bus.mem_ready = 0;
    step();
    check("lw_retired", bus.retired, 4);
    instr(OP_I, ALT, 3'b000);
    step(2);
    check("addi_alu_cc", bus.alu_cc, 4'b0010);
    check("addi_alu_src", bus.alu_src, 1);
    bus.run = 0;
    step();
    check("addi_wb_reg_write", bus.reg_write, 1);
    force dut.retired_q = 16'hFFFF;
    #1 release dut.retired_q;
    step();
    check("halt_state", bus.state, 0);
    check("halt_busy", bus.busy, 0);
    check("wrap_to_zero", bus.retired, 16'h0000);
    step();
    check("halt_hold", bus.state, 0);
    bus.run = 1;
    step();
    check("resume_fetch", bus.state, 1);
    step(3);
    check("resume_wb", bus.state, 5);
    step();
    check("wrap_to_one", bus.retired, 16'h0001);
    instr(OP_SW, 7'd0, 3'b010);
    bus.mem_ready = 1;
    step(3);
    check("sw_mem_state", bus.state, 4);
    check("sw_mem_strobes", {bus.mem_write, bus.pc_en, bus.mem_read}, 3'b110);
    step();
    check("sw_next_fetch", bus.state, 1);
    check("sw_retired", bus.retired, 2);
    bus.mem_ready = 0;
    step(3);
    check("midmem_write", bus.mem_write, 1);
    #2 rst_n = 0;
    #1;
    check("midmem_rst_write", bus.mem_write, 0);
    check("midmem_rst_state", bus.state, 0);
    check("midmem_rst_retired", bus.retired, 0);
    check("midmem_rst_trap", bus.trap, 0);
    @(negedge clk);
    rst_n = 1;
    instr(OP_R, 7'd0, 3'b000);
    step(5);
    check("post_rst_retired", bus.retired, 1);
    instr(OP_SW, 7'd0, 3'b010);
    step(3);
    n = 0;
    for (int i = 0; i < 16; i++) begin
      n += (bus.state == 4 && bus.mem_write) ? 1 : 0;
      step();
    end
    check("timeout_write_cycles", n, 16);
    check("timeout_state", bus.state, 6);
    check("timeout_flags", {bus.trap, bus.busy, bus.mem_write, bus.pc_en}, 4'b1000);
    check("timeout_retired", bus.retired, 1);
    step(10);
    check("timeout_sticky", {bus.trap, bus.state}, {1'b1, 3'd6});
    rst_n = 0;
    step();
    rst_n = 1;
    instr(OP_R, ALT, 3'b111);
    step(3);
    check("illegal_f7_state", bus.state, 6);
    check("illegal_f7_flags", {bus.trap, bus.pc_en, bus.busy}, 3'b100);
    step(10);
    check("illegal_f7_sticky", {bus.trap, bus.state}, {1'b1, 3'd6});
    rst_n = 0;
    step();
    rst_n = 1;
    instr(OP_LW, 7'd0, 3'b000);
    step(3);
    check("illegal_lw_f3", bus.state, 6);
    rst_n = 0;
    step();
    rst_n = 1;
    instr(OP_I, ALT, 3'b001);
    step(3);
    check("illegal_slli_f7", bus.state, 6);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
